// File: rtl/palette_upload_dma.sv
// Palette upload DMA: copies an xBGR555 table from work RAM into the
// palette chip's R/G/B RAMs, one source word per entry, only during VBLANK.
//
// Ports:
//   CLK_32M, RESET        clock, async active-high reset
//   START, VBLANK         upload request, transfer window
//   MEM_RD/ADDR/DATA/ACK  work-RAM read initiator
//   PAL_A/DIN/G/MWR       palette chip write port
//   BUSY, DONE            status, end-of-upload pulse
module palette_upload_dma #(
  parameter int          ENTRIES  = 256,
  parameter logic [19:0] SRC_BASE = 20'h00000
) (
  input  logic        CLK_32M,
  input  logic        RESET,
  input  logic        START,
  input  logic        VBLANK,
  output logic        MEM_RD,
  output logic [19:0] MEM_ADDR,
  input  logic [15:0] MEM_DATA,
  input  logic        MEM_ACK,
  output logic [19:0] PAL_A,
  output logic [15:0] PAL_DIN,
  output logic        PAL_G,
  output logic        PAL_MWR,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_FETCH,
    S_WR_R,
    S_WR_G,
    S_WR_B,
    S_FINISH
  } state_t;

  localparam logic [7:0] LAST = 8'(ENTRIES - 1);

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] data_q, data_d;
  logic        rd_q, rd_d;
  logic [19:0] addr_q, addr_d;
  logic [19:0] pal_a_q, pal_a_d;
  logic [15:0] pal_din_q, pal_din_d;
  logic        wr_q, wr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [1:0]  comp;
  logic [4:0]  comp_val;

  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      pal_a_q   <= '0;
      pal_din_q <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      pal_a_q   <= pal_a_d;
      pal_din_q <= pal_din_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Outputs are registered from the next state, so each one is valid
  // for exactly the cycles the FSM spends in the matching state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    addr_d    = addr_q;
    comp      = 2'b00;
    comp_val  = 5'd0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    pal_a_d   = '0;
    pal_din_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_ARMED;
          idx_d   = '0;
        end
      end
      S_ARMED: begin
        if (VBLANK) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (rd_q && MEM_ACK) begin
          data_d  = MEM_DATA;
          state_d = S_WR_R;
        end
      end
      S_WR_R: state_d = S_WR_G;
      S_WR_G: state_d = S_WR_B;
      S_WR_B: begin
        if (idx_q == LAST) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = VBLANK ? S_FETCH : S_ARMED;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // data_d already carries MEM_DATA on the FETCH->WR_R edge.
    unique case (state_d)
      S_WR_R: begin
        wr_d     = 1'b1;
        comp     = 2'b00;
        comp_val = data_d[4:0];
      end
      S_WR_G: begin
        wr_d     = 1'b1;
        comp     = 2'b01;
        comp_val = data_d[9:5];
      end
      S_WR_B: begin
        wr_d     = 1'b1;
        comp     = 2'b10;
        comp_val = data_d[14:10];
      end
      default: begin
        wr_d = 1'b0;
      end
    endcase

    if (wr_d) begin
      pal_a_d   = {8'd0, comp, 1'b0, idx_d, 1'b0};
      pal_din_d = {11'd0, comp_val};
    end

    if (state_d == S_FETCH) begin
      rd_d   = 1'b1;
      addr_d = SRC_BASE + {11'd0, idx_d, 1'b0};
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  assign MEM_RD   = rd_q;
  assign MEM_ADDR = addr_q;
  assign PAL_A    = pal_a_q;
  assign PAL_DIN  = pal_din_q;
  assign PAL_G    = wr_q;
  assign PAL_MWR  = wr_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_palette_upload_dma.sv
// Bench for palette_upload_dma: random palette tables and RAM latency,
// write stream checked against a per-entry/per-component model.
module tb_palette_upload_dma;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // main instance, 256 entries
  logic        START = 1'b0, VBLANK = 1'b0;
  logic        MEM_RD, MEM_ACK = 1'b0;
  logic [19:0] MEM_ADDR, PAL_A;
  logic [15:0] MEM_DATA = 16'h0, PAL_DIN;
  logic        PAL_G, PAL_MWR, BUSY, DONE;

  palette_upload_dma #(.ENTRIES(256), .SRC_BASE(20'h00000)) dut (
    .CLK_32M(clk), .RESET(RESET), .START(START), .VBLANK(VBLANK),
    .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .MEM_ACK(MEM_ACK), .PAL_A(PAL_A), .PAL_DIN(PAL_DIN), .PAL_G(PAL_G),
    .PAL_MWR(PAL_MWR), .BUSY(BUSY), .DONE(DONE)
  );

  // small instance, 16 entries
  logic        s_start = 1'b0, s_vb = 1'b0;
  logic        s_rd, s_ack = 1'b0;
  logic [19:0] s_addr, s_a;
  logic [15:0] s_data = 16'h0, s_din;
  logic        s_g, s_mwr, s_busy, s_done;

  palette_upload_dma #(.ENTRIES(16), .SRC_BASE(20'h00000)) dut16 (
    .CLK_32M(clk), .RESET(RESET), .START(s_start), .VBLANK(s_vb),
    .MEM_RD(s_rd), .MEM_ADDR(s_addr), .MEM_DATA(s_data),
    .MEM_ACK(s_ack), .PAL_A(s_a), .PAL_DIN(s_din), .PAL_G(s_g),
    .PAL_MWR(s_mwr), .BUSY(s_busy), .DONE(s_done)
  );

  // work RAM model; lat = cycles MEM_RD is held (0 = random 1..3)
  logic [15:0] src [256];
  int lat = 1;
  int rcnt = 0;
  int cur_lat = 1;

  always @(negedge clk) begin
    if (MEM_RD) begin
      if (rcnt == 0) cur_lat = (lat <= 0) ? int'($urandom_range(1, 3)) : lat;
      rcnt++;
      if (rcnt >= cur_lat) begin
        MEM_ACK  = 1'b1;
        MEM_DATA = src[MEM_ADDR[8:1]];
      end else begin
        MEM_ACK  = 1'b0;
        MEM_DATA = 16'($urandom);
      end
    end else begin
      MEM_ACK = 1'b0;
      rcnt    = 0;
    end
    s_ack  = s_rd;
    s_data = 16'h0421;
  end

  // observation queues
  logic [35:0] wq [$];
  int          wcyc [$];
  logic [19:0] aq [$];
  int done_cnt = 0, done_cyc = 0, busy_cyc = 0, rd_cyc = 0;
  int addr_chg = 0, gm_bad = 0;
  logic        prev_rd = 1'b0;
  logic [19:0] prev_addr = '0;

  logic [35:0] w16 [$];
  int          w16cyc [$];
  logic [19:0] aq16 [$];
  int done16 = 0, done16_cyc = 0;

  always @(negedge clk) begin
    if (PAL_G || PAL_MWR) begin
      wq.push_back({PAL_A, PAL_DIN});
      wcyc.push_back(cyc);
      if (!(PAL_G && PAL_MWR)) gm_bad++;
    end
    if (DONE) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (BUSY) busy_cyc++;
    if (MEM_RD) begin
      rd_cyc++;
      if (!prev_rd) aq.push_back(MEM_ADDR);
      else if (MEM_ADDR != prev_addr) addr_chg++;
    end
    prev_rd   = MEM_RD;
    prev_addr = MEM_ADDR;

    if (s_g || s_mwr) begin
      w16.push_back({s_a, s_din});
      w16cyc.push_back(cyc);
    end
    if (s_done) begin
      done16++;
      done16_cyc = cyc;
    end
    if (s_rd && !s_ack) aq16.push_back(s_addr);
    else if (s_rd) aq16.push_back(s_addr);
  end

  // reference: entry i, component c (0=R,1=G,2=B) of source word w
  function automatic logic [35:0] exp_wr(int i, int c, logic [15:0] w);
    int a, d;
    a = c * 1024 + i * 2;
    d = (int'(w) / (1 << (5 * c))) % 32;
    return {a[19:0], d[15:0]};
  endfunction

  task automatic clear_mon();
    wq.delete(); wcyc.delete(); aq.delete();
    done_cnt = 0; busy_cyc = 0; rd_cyc = 0;
    addr_chg = 0; gm_bad = 0;
  endtask

  task automatic fill_src();
    for (int i = 0; i < 256; i++) src[i] = 16'($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clk); START = 1'b1;
    @(negedge clk); START = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({MEM_RD, PAL_G, PAL_MWR, BUSY, DONE} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctl got %b want 00000",
               {MEM_RD, PAL_G, PAL_MWR, BUSY, DONE});
    end
    n_cmp++;
    if ({MEM_ADDR, PAL_A, PAL_DIN} !== 56'h0) begin
      n_bad++;
      $display("FAIL reset_bus got %h want 0", {MEM_ADDR, PAL_A, PAL_DIN});
    end
    RESET = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (BUSY !== 1'b0 || s_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_busy got %b%b want 00", BUSY, s_busy);
    end
  endtask

  task automatic test_zero_wait();
    int n;
    fill_src();
    src[5] = 16'h7FFF;
    lat = 1;
    VBLANK = 1'b1;
    clear_mon();
    pulse_start();
    n = 0;
    while (!DONE && n < 2000) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 2000) begin n_bad++; $display("FAIL t1_timeout got %0d want <2000", n); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (wq.size() != 768) begin
      n_bad++; $display("FAIL t1_count got %0d want 768", wq.size());
    end
    for (int k = 0; k < 768; k++) begin
      n_cmp++;
      if (wq[k] !== exp_wr(k / 3, k % 3, src[k / 3])) begin
        n_bad++;
        $display("FAIL t1_wr%0d got %h want %h", k, wq[k],
                 exp_wr(k / 3, k % 3, src[k / 3]));
      end
    end
    n_cmp++;
    if ({wq[15], wq[16], wq[17]} !== {20'h00A, 16'h1F, 20'h40A, 16'h1F,
                                      20'h80A, 16'h1F}) begin
      n_bad++;
      $display("FAIL t1_entry5 got %h %h %h want 00a/40a/80a din 1f",
               wq[15], wq[16], wq[17]);
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++; $display("FAIL t1_done got %0d want 1", done_cnt);
    end
    n_cmp++;
    if (busy_cyc != 1026) begin
      n_bad++; $display("FAIL t1_busy_cycles got %0d want 1026", busy_cyc);
    end
    n_cmp++;
    if (rd_cyc != 256) begin
      n_bad++; $display("FAIL t1_rd_cycles got %0d want 256", rd_cyc);
    end
    n_cmp++;
    if (gm_bad != 0) begin
      n_bad++; $display("FAIL t1_g_mwr got %0d want 0", gm_bad);
    end
  endtask

  task automatic test_ack_latency();
    int n;
    fill_src();
    lat = 3;
    VBLANK = 1'b1;
    clear_mon();
    pulse_start();
    n = 0;
    while (!DONE && n < 4000) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 4000) begin n_bad++; $display("FAIL t2_timeout got %0d want <4000", n); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (wq.size() != 768) begin
      n_bad++; $display("FAIL t2_count got %0d want 768", wq.size());
    end
    for (int k = 0; k < 768; k++) begin
      n_cmp++;
      if (wq[k] !== exp_wr(k / 3, k % 3, src[k / 3])) begin
        n_bad++;
        $display("FAIL t2_wr%0d got %h want %h", k, wq[k],
                 exp_wr(k / 3, k % 3, src[k / 3]));
      end
    end
    n_cmp++;
    if (rd_cyc != 768) begin
      n_bad++; $display("FAIL t2_rd_cycles got %0d want 768", rd_cyc);
    end
    n_cmp++;
    if (addr_chg != 0) begin
      n_bad++; $display("FAIL t2_addr_stable got %0d want 0", addr_chg);
    end
    for (int i = 0; i < 256; i += 17) begin
      n_cmp++;
      if (aq[i] !== 20'(2 * i)) begin
        n_bad++; $display("FAIL t2_addr%0d got %h want %h", i, aq[i], 20'(2 * i));
      end
    end
  endtask

  task automatic test_vblank_pause();
    int n;
    int sz;
    fill_src();
    lat = 0;
    VBLANK = 1'b1;
    clear_mon();
    pulse_start();
    n = 0;
    while (!(PAL_G && PAL_A == 20'h450) && n < 2000) begin
      @(negedge clk); n++;
    end
    n_cmp++;
    if (n >= 2000) begin n_bad++; $display("FAIL t3_find_wrg40 got %0d want <2000", n); end
    VBLANK = 1'b0;
    repeat (20) @(negedge clk);
    sz = wq.size();
    n_cmp++;
    if (sz != 123) begin
      n_bad++; $display("FAIL t3_paused_count got %0d want 123", sz);
    end
    n_cmp++;
    if (wq[122] !== exp_wr(40, 2, src[40])) begin
      n_bad++; $display("FAIL t3_wrb40 got %h want %h", wq[122], exp_wr(40, 2, src[40]));
    end
    n_cmp++;
    if (BUSY !== 1'b1 || MEM_RD !== 1'b0) begin
      n_bad++; $display("FAIL t3_armed got busy%b rd%b want busy1 rd0", BUSY, MEM_RD);
    end
    VBLANK = 1'b1;
    n = 0;
    while (!DONE && n < 2000) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 2000) begin n_bad++; $display("FAIL t3_timeout got %0d want <2000", n); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (aq[41] !== 20'h00052) begin
      n_bad++; $display("FAIL t3_resume_addr got %h want 00052", aq[41]);
    end
    n_cmp++;
    if (wq.size() != 768) begin
      n_bad++; $display("FAIL t3_count got %0d want 768", wq.size());
    end
    for (int k = 0; k < 768; k++) begin
      n_cmp++;
      if (wq[k] !== exp_wr(k / 3, k % 3, src[k / 3])) begin
        n_bad++;
        $display("FAIL t3_wr%0d got %h want %h", k, wq[k],
                 exp_wr(k / 3, k % 3, src[k / 3]));
      end
    end
  endtask

  task automatic test_start_while_busy();
    int n;
    fill_src();
    lat = 0;
    VBLANK = 1'b1;
    clear_mon();
    pulse_start();
    for (int p = 0; p < 4; p++) begin
      repeat ($urandom_range(20, 150)) @(negedge clk);
      START = 1'b1;
      @(negedge clk);
      START = 1'b0;
    end
    n = 0;
    while (!DONE && n < 2000) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 2000) begin n_bad++; $display("FAIL t4_timeout got %0d want <2000", n); end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (done_cnt != 1 || BUSY !== 1'b0) begin
      n_bad++; $display("FAIL t4_single_done got %0d busy %b want 1 busy 0",
                        done_cnt, BUSY);
    end
    n_cmp++;
    if (wq.size() != 768) begin
      n_bad++; $display("FAIL t4_count got %0d want 768", wq.size());
    end
    for (int k = 0; k < 768; k++) begin
      n_cmp++;
      if (wq[k] !== exp_wr(k / 3, k % 3, src[k / 3])) begin
        n_bad++;
        $display("FAIL t4_wr%0d got %h want %h", k, wq[k],
                 exp_wr(k / 3, k % 3, src[k / 3]));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int sz;
    fill_src();
    lat = 0;
    VBLANK = 1'b1;
    clear_mon();
    pulse_start();
    n = 0;
    while (!(PAL_G && PAL_A == 20'h000C8) && n < 2000) begin
      @(negedge clk); n++;
    end
    n_cmp++;
    if (n >= 2000) begin n_bad++; $display("FAIL t5_find_wrr100 got %0d want <2000", n); end
    RESET = 1'b1;
    #1;
    n_cmp++;
    if ({PAL_G, PAL_MWR, MEM_RD, BUSY} !== 4'b0) begin
      n_bad++; $display("FAIL t5_async got %b want 0000",
                        {PAL_G, PAL_MWR, MEM_RD, BUSY});
    end
    sz = wq.size();
    n_cmp++;
    if (sz != 301) begin
      n_bad++; $display("FAIL t5_before got %0d want 301", sz);
    end
    repeat (10) @(negedge clk);
    RESET = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (wq.size() != sz || BUSY !== 1'b0) begin
      n_bad++; $display("FAIL t5_quiet got %0d busy %b want %0d busy 0",
                        wq.size(), BUSY, sz);
    end
    clear_mon();
    pulse_start();
    n = 0;
    while (!DONE && n < 2000) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 2000) begin n_bad++; $display("FAIL t5_timeout got %0d want <2000", n); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (wq.size() != 768 || aq[0] !== 20'h0) begin
      n_bad++; $display("FAIL t5_restart got %0d first %h want 768 first 0",
                        wq.size(), aq[0]);
    end
    for (int k = 0; k < 768; k += 5) begin
      n_cmp++;
      if (wq[k] !== exp_wr(k / 3, k % 3, src[k / 3])) begin
        n_bad++;
        $display("FAIL t5_wr%0d got %h want %h", k, wq[k],
                 exp_wr(k / 3, k % 3, src[k / 3]));
      end
    end
  endtask

  task automatic test_small_table();
    int n;
    int maxa;
    s_vb = 1'b1;
    w16.delete(); w16cyc.delete(); aq16.delete();
    done16 = 0;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    n = 0;
    while (!s_done && n < 500) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 500) begin n_bad++; $display("FAIL t6_timeout got %0d want <500", n); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (w16.size() != 48) begin
      n_bad++; $display("FAIL t6_count got %0d want 48", w16.size());
    end
    for (int k = 0; k < 48; k++) begin
      n_cmp++;
      if (w16[k] !== exp_wr(k / 3, k % 3, 16'h0421)) begin
        n_bad++;
        $display("FAIL t6_wr%0d got %h want %h", k, w16[k],
                 exp_wr(k / 3, k % 3, 16'h0421));
      end
    end
    n_cmp++;
    if (done16 != 1 || done16_cyc != w16cyc[47] + 1) begin
      n_bad++; $display("FAIL t6_done got %0d at %0d want 1 at %0d",
                        done16, done16_cyc, w16cyc[47] + 1);
    end
    maxa = 0;
    foreach (aq16[i]) if (int'(aq16[i]) > maxa) maxa = int'(aq16[i]);
    n_cmp++;
    if (aq16.size() != 16 || maxa != 30) begin
      n_bad++; $display("FAIL t6_fetches got %0d max %h want 16 max 1e",
                        aq16.size(), maxa);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_ack_latency();
    test_vblank_pause();
    test_start_while_busy();
    test_reset_mid();
    test_small_table();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
